// File: rtl/mux_arbiter_2x1.sv
// Two-requester burst arbiter with a registered output mux.
// Round-robin on contention, bursts capped at MAX_BURST only while the other side waits.
module mux_arbiter_2x1 #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             last_a,
    input  logic             last_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_fav_a;

    logic       w_xfer_a;
    logic       w_xfer_b;
    logic [3:0] w_cnt_inc;
    logic       w_cap;
    logic       w_rel_a;
    logic       w_rel_b;

    assign w_xfer_a  = (r_state == GRANT_A) && req_a;
    assign w_xfer_b  = (r_state == GRANT_B) && req_b;
    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_cap     = (w_cnt_inc == BURST_LIM);

    // A dropped req releases without a transfer; the burst cap only releases under contention.
    assign w_rel_a = !req_a || last_a || (w_cap && req_b);
    assign w_rel_b = !req_b || last_b || (w_cap && req_a);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_fav_a   <= 1'b1;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= w_xfer_a || w_xfer_b;
            if (w_xfer_a) begin
                out_data <= data_a;
            end else if (w_xfer_b) begin
                out_data <= data_b;
            end

            case (r_state)
                IDLE: begin
                    if (req_a && (!req_b || r_fav_a)) begin
                        r_state <= GRANT_A;
                        gnt_a   <= 1'b1;
                        gnt_b   <= 1'b0;
                        sel     <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_fav_a <= 1'b0;
                    end else if (req_b) begin
                        r_state <= GRANT_B;
                        gnt_a   <= 1'b0;
                        gnt_b   <= 1'b1;
                        sel     <= 1'b0;
                        r_cnt   <= 4'd0;
                        r_fav_a <= 1'b1;
                    end
                end

                GRANT_A: begin
                    if (w_rel_a) begin
                        if (req_b) begin
                            r_state <= GRANT_B;
                            gnt_a   <= 1'b0;
                            gnt_b   <= 1'b1;
                            sel     <= 1'b0;
                            r_cnt   <= 4'd0;
                            r_fav_a <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            gnt_a   <= 1'b0;
                            gnt_b   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cap ? 4'd0 : w_cnt_inc;
                    end
                end

                GRANT_B: begin
                    if (w_rel_b) begin
                        if (req_a) begin
                            r_state <= GRANT_A;
                            gnt_a   <= 1'b1;
                            gnt_b   <= 1'b0;
                            sel     <= 1'b1;
                            r_cnt   <= 4'd0;
                            r_fav_a <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            gnt_a   <= 1'b0;
                            gnt_b   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cap ? 4'd0 : w_cnt_inc;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    gnt_a   <= 1'b0;
                    gnt_b   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter_2x1.sv
// Bench for mux_arbiter_2x1: directed scenarios plus random traffic against a behavioural model.
module tb_mux_arbiter_2x1;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk  = 1'b0;
    logic             rstn = 1'b1;
    logic             req_a = 1'b0, req_b = 1'b0, last_a = 1'b0, last_b = 1'b0;
    logic [WIDTH-1:0] data_a = '0, data_b = '0;
    logic             gnt_a, gnt_b, sel, out_valid;
    logic [WIDTH-1:0] out_data;

    int n_chk = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B
    int               m_owner;
    int               m_cnt;
    bit               m_fav_a;
    bit               m_sel;
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    bit               m_xa, m_xb;

    mux_arbiter_2x1 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rstn(rstn),
        .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_fav_a = 1; m_sel = 0;
        m_ov = 0; m_od = '0; m_xa = 0; m_xb = 0;
    endtask

    task automatic model_grant(input int id);
        m_owner = id;
        m_cnt   = 0;
        m_fav_a = (id == 2);
    endtask

    task automatic model_step();
        bit mine, other_req, my_last, rel;
        m_xa = (m_owner == 1) && req_a;
        m_xb = (m_owner == 2) && req_b;
        m_ov = m_xa || m_xb;
        if (m_xa) m_od = data_a;
        else if (m_xb) m_od = data_b;
        if (m_owner == 0) begin
            if (req_a && req_b) model_grant(m_fav_a ? 1 : 2);
            else if (req_a) model_grant(1);
            else if (req_b) model_grant(2);
        end else begin
            mine      = (m_owner == 1) ? req_a  : req_b;
            other_req = (m_owner == 1) ? req_b  : req_a;
            my_last   = (m_owner == 1) ? last_a : last_b;
            rel = 0;
            if (!mine) rel = 1;
            else begin
                m_cnt++;
                if (my_last) rel = 1;
                else if (m_cnt == MAX_BURST) begin
                    if (other_req) rel = 1;
                    else m_cnt = 0;
                end
            end
            if (rel) begin
                if (other_req) model_grant(3 - m_owner);
                else m_owner = 0;
            end
        end
        if (m_owner == 1) m_sel = 1;
        else if (m_owner == 2) m_sel = 0;
    endtask

    task automatic check_outs();
        chk_val("gnt_a", gnt_a, m_owner == 1);
        chk_val("gnt_b", gnt_b, m_owner == 2);
        chk_val("sel", sel, m_sel);
        chk_val("out_valid", out_valid, m_ov);
        chk_val("out_data", out_data, m_od);
        chk_val("gnt_exclusive", gnt_a & gnt_b, 0);
    endtask

    // Inputs are driven at the falling edge; the model advances on the rising edge.
    task automatic step();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_step();
        #1 check_outs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_a = 0; req_b = 0; last_a = 0; last_b = 0;
        rstn = 0;
        step();
        step();
        rstn = 1;
    endtask

    initial begin : main
        logic [WIDTH-1:0] words [3];
        int idx, nv, ca, cb, na;
        bit prev_ga, handover, seen_b;

        #1 rstn = 0;
        model_reset();
        #1;
        chk_val("rst_gnt_a", gnt_a, 0);
        chk_val("rst_gnt_b", gnt_b, 0);
        chk_val("rst_sel", sel, 0);
        chk_val("rst_out_valid", out_valid, 0);
        chk_val("rst_out_data", out_data, 0);
        @(negedge clk);
        do_reset();

        // Single requester, three-word burst
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        idx = 0; nv = 0;
        req_a = 1; data_a = words[0]; last_a = 0;
        step();
        chk_val("t1_gnt_a_rise", gnt_a, 1);
        chk_val("t1_sel", sel, 1);
        for (int c = 0; c < 6; c++) begin
            if (m_xa) idx++;
            req_a  = (idx < 3);
            data_a = (idx < 3) ? words[idx] : '0;
            last_a = (idx == 2);
            step();
            if (out_valid) begin
                if (nv < 3) chk_val("t1_word", out_data, words[nv]);
                else chk_val("t1_extra_word", out_valid, 0);
                nv++;
            end
        end
        chk_val("t1_nwords", nv, 3);
        chk_val("t1_idle", gnt_a | gnt_b, 0);

        // Simultaneous request out of reset: A first, then B with no gap
        do_reset();
        req_a = 1; req_b = 1; data_a = 8'hA1; data_b = 8'hB1;
        ca = 0; cb = 0; handover = 0; prev_ga = 0;
        step();
        chk_val("t2_a_first", gnt_a, 1);
        chk_val("t2_b_waits", gnt_b, 0);
        for (int c = 0; c < 10; c++) begin
            if (m_xa) ca++;
            if (m_xb) cb++;
            req_a = (ca < 2); last_a = (ca == 1);
            req_b = (cb < 2); last_b = (cb == 1);
            prev_ga = gnt_a;
            step();
            if (prev_ga && !gnt_a) begin
                chk_val("t2_no_gap", gnt_b, 1);
                chk_val("t2_sel_to_b", sel, 0);
                handover = 1;
            end
        end
        chk_val("t2_handover_seen", handover, 1);

        // Preemption after MAX_BURST words while B waits
        do_reset();
        req_a = 1; req_b = 1; last_a = 0; last_b = 0;
        data_a = 8'hA5; data_b = 8'h5B;
        na = 0; seen_b = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid && out_data == 8'h5B) seen_b = 1;
            if (out_valid && out_data == 8'hA5 && !seen_b) na++;
        end
        chk_val("t3_a_words", na, MAX_BURST);
        chk_val("t3_b_granted", seen_b, 1);

        // No contention: A keeps the grant past MAX_BURST
        req_a = 0; req_b = 0;
        step();
        step();
        req_a = 1;
        step();
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            data_a = 8'(c + 1);
            step();
            chk_val("t4_gnt_a_held", gnt_a, 1);
            if (out_valid) nv++;
        end
        chk_val("t4_nwords", nv, 10);

        // B drops out with A idle
        req_a = 0;
        step();
        req_b = 1; data_b = 8'hC3;
        step();
        step();
        req_b = 0;
        step();
        chk_val("t5_gnt_b_off", gnt_b, 0);
        chk_val("t5_out_valid", out_valid, 0);
        chk_val("t5_sel_hold", sel, 0);
        step();
        chk_val("t5_sel_hold2", sel, 0);

        // Asynchronous reset in the middle of a B burst
        req_b = 1; data_b = 8'h7E;
        step();
        step();
        chk_val("t6_pre_gnt_b", gnt_b, 1);
        rstn = 0;
        #1;
        model_reset();
        chk_val("t6_async_gnt_b", gnt_b, 0);
        chk_val("t6_async_valid", out_valid, 0);
        chk_val("t6_async_data", out_data, 0);
        req_a = 1; req_b = 1;
        @(negedge clk);
        step();
        rstn = 1;
        step();
        chk_val("t6_a_first", gnt_a, 1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_a  = ($urandom_range(0, 9) < 7);
            req_b  = ($urandom_range(0, 9) < 6);
            last_a = ($urandom_range(0, 5) == 0);
            last_b = ($urandom_range(0, 5) == 0);
            data_a = WIDTH'($urandom);
            data_b = WIDTH'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
